dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Arbiter and sequencer placed in front of the 1K×32 data memory, `datamem`. It shares that memory between the scalar RV32IMC core and the vector coprocessor. Core accesses are single transfers with byte-lane enables. Vector accesses are strided bursts of full-word reads or writes, which the block expands into one memory access per cycle. Arbitration is round-robin at transaction granularity, and a vector burst is never interrupted.

## Interface
- `ADDR_W`, 10, word-address width of the data memory
- `DATA_W`, 32, data width
- `LEN_W`, 5, width of the burst-length field (0..31 elements)
- `core_clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `c_req`  in  1  core request; the requester holds it and all `c_*` fields stable until `c_gnt`
- `c_we`  in  4  core byte-lane write enables; 0 means read
- `c_addr`  in  ADDR_W  core word address
- `c_wdata`  in  DATA_W  core write data
- `c_gnt`  out  1  core access issued to memory this cycle
- `c_rvalid`  out  1  core read data valid (read accesses only)
- `c_rdata`  out  DATA_W  core read data
- `v_req`  in  1  vector burst request; held with the `v_*` fields until `v_gnt`
- `v_we`  in  1  burst direction: 1 = write (all four lanes), 0 = read
- `v_base`  in  ADDR_W  address of element 0
- `v_stride`  in  ADDR_W  element stride in words, unsigned
- `v_len`  in  LEN_W  element count
- `v_wdata`  in  DATA_W  write element, consumed when `v_wready` is high
- `v_gnt`  out  1  one-cycle pulse; burst parameters latched
- `v_wready`  out  1  current write element issued to memory
- `v_rvalid`  out  1  read element valid
- `v_rdata`  out  DATA_W  read element data
- `v_ridx`  out  LEN_W  index of the element on `v_rdata`
- `v_done`  out  1  one-cycle pulse at burst completion
- `dm_write`  out  4  to `datamem`, byte write enables
- `data_addr`  out  ADDR_W  to `datamem`, word address
- `data_in`  out  DATA_W  to `datamem`, write data
- `data_out`  in  DATA_W  from `datamem`, read data, valid one cycle after the address is presented

## Operation
- **States:** IDLE and VBURST. A pointer `last` records the most recent winner; reset sets `last` to vector, so the core wins first.
- **IDLE arbitration:**
  - Only `c_req` high: core wins.
  - Only `v_req` high: vector wins.
  - Both high: the requester that is not `last` wins.
  - Neither high: memory outputs are all zero.
- **Core win** (combinational, same cycle):
  - `c_gnt`=1.
  - `dm_write`=`c_we`, `data_addr`=`c_addr`, `data_in`=`c_wdata`.
  - `last` becomes core; the state stays IDLE.
- **Vector win:**
  - `v_gnt`=1.
  - Latch `v_we`, `v_base`, `v_stride`, `v_len`; element counter `i` is set to 0.
  - `last` becomes vector.
  - No memory access in the grant cycle. Go to VBURST; if `v_len`=0, go to IDLE instead.
- **VBURST:**
  - Element address is `base + i*stride`, truncated to ADDR_W bits, so it wraps modulo 1024. It is computed by accumulation, with no multiplier.
  - Write element: `dm_write`=4'b1111, `data_in`=`v_wdata`, `v_wready`=1.
  - Read element: `dm_write`=0; the index is captured for `v_ridx`.
  - `i` increments every cycle. After element `len`-1 the state returns to IDLE.
  - `c_gnt` stays low throughout the burst; the core stalls.
- **`v_len`=0:** the grant is followed by a `v_done` pulse on the next cycle, with no memory access.

## Timing
- **Reset values:** every output is 0; state is IDLE, `i`=0, `last`=vector.
- **Reset mid-burst:**
  - Outputs clear immediately (asynchronous) and the burst is abandoned.
  - Elements already written remain in memory.
  - No `v_done` is issued; pending `rvalid`s are dropped.
- **Core read:** issued at cycle t; `c_rvalid`=1 with `c_rdata`=`data_out` at t+1. Core writes produce no `rvalid`.
- **Vector read burst:** element k is issued at grant+1+k. `v_rvalid`, `v_rdata` and `v_ridx`=k follow one cycle later.
- **`v_done`:** asserted in the cycle after the last element is issued, together with the last read's `v_rvalid`.
- **Back-to-back traffic:**
  - Core alone can issue one access per cycle with no bubble.
  - The earliest a new request can win IDLE arbitration is the cycle `v_done` is high.
  - A request that loses arbitration waits; with both requesters continuously active, grants alternate strictly.
- **Width rules:** the stride product is not computed explicitly; the accumulator wraps naturally at ADDR_W bits.

## Test plan
- **Reset, then core traffic:** core SW 0x12345678 to addr 5, then a read of addr 5. Required: `c_gnt` in each request cycle, `dm_write`=1111 on the write, `c_rvalid` with `c_rdata`=0x12345678 one cycle after the read.
- **Vector write then read burst:** base 0x010, stride 2, len 4, write data 0xA0..0xA3. Required: `data_addr` 0x010, 0x012, 0x014, 0x016 on consecutive cycles, each with `v_wready`=1. A subsequent read burst returns 0xA0..0xA3 with `v_ridx` 0..3, and `v_done` coincides with `v_ridx`=3.
- **Wrap-around:** base 0x3FE, stride 1, len 4. Required addresses 0x3FE, 0x3FF, 0x000, 0x001.
- **Simultaneous requests after reset:** core wins first. With the core request held throughout a len-3 burst, `c_gnt` is low for the three burst cycles and the grant sequence is core, vector, core.
- **`v_len`=0:** `v_gnt`, then `v_done` on the next cycle; `dm_write` and `data_addr` stay 0.
- **`rst` pulsed at element 2 of a len-8 write burst:** outputs are 0 immediately, elements 0-1 are written, elements 2-7 are untouched, no `v_done`, and the next request is arbitrated normally.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of datamem between core single accesses and vector strided bursts
module dm_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              core_clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic [3:0]        c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [ADDR_W-1:0] v_stride,
  input  logic [LEN_W-1:0]  v_len,
  input  logic [DATA_W-1:0] v_wdata,
  output logic              v_gnt,
  output logic              v_wready,
  output logic              v_rvalid,
  output logic [DATA_W-1:0] v_rdata,
  output logic [LEN_W-1:0]  v_ridx,
  output logic              v_done,
  output logic [3:0]        dm_write,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);
  typedef enum logic {IDLE, VBURST} state_t;
  state_t state, state_n;
  logic last;
  logic bw;
  logic [ADDR_W-1:0] baddr, bstride;
  logic [LEN_W-1:0] blen, i;
  logic c_win, v_win, burst, last_el;
  // last = 1 means the vector side won most recently, so the core has priority
  assign c_win   = !rst && state == IDLE && c_req && (!v_req || last);
  assign v_win   = !rst && state == IDLE && v_req && (!c_req || !last);
  assign burst   = state == VBURST;
  assign last_el = i == blen - LEN_W'(1);
  always_ff @(posedge core_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = v_win ? (v_len != '0 ? VBURST : IDLE) : (burst && last_el) ? IDLE : state;
  // baddr accumulates the stride each element, wrapping at ADDR_W bits
  always_ff @(posedge core_clk or posedge rst)
    if (rst) begin
      last     <= 1'b1;
      bw       <= 1'b0;
      baddr    <= '0;
      bstride  <= '0;
      blen     <= '0;
      i        <= '0;
      c_rvalid <= 1'b0;
      v_rvalid <= 1'b0;
      v_ridx   <= '0;
      v_done   <= 1'b0;
    end else begin
      if (c_win) last <= 1'b0;
      if (v_win) begin
        last    <= 1'b1;
        bw      <= v_we;
        baddr   <= v_base;
        bstride <= v_stride;
        blen    <= v_len;
        i       <= '0;
      end else if (burst) begin
        baddr <= baddr + bstride;
        i     <= i + LEN_W'(1);
      end
      c_rvalid <= c_win && c_we == 4'b0000;
      v_rvalid <= burst && !bw;
      v_ridx   <= (burst && !bw) ? i : '0;
      v_done   <= (v_win && v_len == '0) || (burst && last_el);
    end
  always_comb begin
    c_gnt     = c_win;
    v_gnt     = v_win;
    v_wready  = burst && bw;
    dm_write  = c_win ? c_we : v_wready ? 4'b1111 : 4'b0000;
    data_addr = c_win ? c_addr : burst ? baddr : '0;
    data_in   = c_win ? c_wdata : v_wready ? v_wdata : '0;
    c_rdata   = c_rvalid ? data_out : '0;
    v_rdata   = v_rvalid ? data_out : '0;
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table, hand-written and random checks of dm_arbiter against a memory-level model
module tb_dm_arbiter;
  logic        core_clk, rst;
  logic        c_req, c_gnt, c_rvalid;
  logic [3:0]  c_we;
  logic [9:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic        v_req, v_we, v_gnt, v_wready, v_rvalid, v_done;
  logic [9:0]  v_base, v_stride;
  logic [4:0]  v_len, v_ridx;
  logic [31:0] v_wdata, v_rdata;
  logic [3:0]  dm_write;
  logic [9:0]  data_addr;
  logic [31:0] data_in, data_out;

  dm_arbiter dut (
    .core_clk(core_clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .v_req(v_req), .v_we(v_we), .v_base(v_base), .v_stride(v_stride), .v_len(v_len),
    .v_wdata(v_wdata), .v_gnt(v_gnt), .v_wready(v_wready), .v_rvalid(v_rvalid),
    .v_rdata(v_rdata), .v_ridx(v_ridx), .v_done(v_done),
    .dm_write(dm_write), .data_addr(data_addr), .data_in(data_in), .data_out(data_out)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic [31:0] mem [1024];
  always @(posedge core_clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_write[b]) mem[data_addr][8*b +: 8] <= data_in[8*b +: 8];
    data_out <= mem[data_addr];
  end

  logic [31:0] gm [1024];
  logic [31:0] vw [32];
  int tests = 0, fails = 0;

  typedef struct {
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } cvec_t;
  cvec_t tbl [7];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic step;
    @(posedge core_clk);
    #1;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ctl"}, {c_gnt, v_gnt, v_wready, v_rvalid, v_done, c_rvalid, dm_write, v_ridx}, 0);
    chk({n, "_mem"}, {data_addr, data_in}, 0);
    chk({n, "_rd"}, {c_rdata, v_rdata}, 0);
  endtask

  task automatic wait_gnt(input bit vec, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge core_clk);
      if (vec ? v_gnt : c_gnt) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    tests++;
    fails++;
    $display("FAIL %s_gnt_timeout actual=0 expected=1", vec ? "v" : "c");
  endtask

  task automatic core_op(input logic [3:0] we, input logic [9:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp);
    bit ok;
    c_req = 1; c_we = we; c_addr = addr; c_wdata = wd;
    wait_gnt(0, ok);
    if (ok) begin
      chk("c_dm_write", dm_write, we);
      chk("c_data_addr", data_addr, addr);
      if (we != 0) chk("c_data_in", data_in, wd);
    end
    for (int b = 0; b < 4; b++)
      if (we[b]) gm[addr][8*b +: 8] = wd[8*b +: 8];
    step();
    c_req = 0;
    @(negedge core_clk);
    chk("c_rvalid", c_rvalid, we == 0);
    if (we == 0) chk("c_rdata", c_rdata, exp);
    step();
  endtask

  task automatic vec_burst(input logic we, input logic [9:0] base, input logic [9:0] stride,
                           input logic [4:0] len);
    bit ok;
    logic [9:0] a, prev;
    prev = '0;
    v_req = 1; v_we = we; v_base = base; v_stride = stride; v_len = len;
    wait_gnt(1, ok);
    step();
    v_req = 0;
    if (!ok) return;
    for (int k = 0; k < int'(len); k++) begin
      a = base + 10'(k) * stride;
      v_wdata = vw[k];
      @(negedge core_clk);
      chk("v_data_addr", data_addr, a);
      chk("v_dm_write", dm_write, we ? 4'hF : 4'h0);
      chk("v_wready", v_wready, we);
      if (we) chk("v_data_in", data_in, vw[k]);
      if (!we && k > 0) begin
        chk("v_rvalid", v_rvalid, 1);
        chk("v_ridx", v_ridx, k - 1);
        chk("v_rdata", v_rdata, gm[prev]);
      end
      if (we) gm[a] = vw[k];
      prev = a;
      step();
    end
    @(negedge core_clk);
    chk("v_done", v_done, 1);
    if (len == 0) chk("v_len0_mem", {dm_write, data_addr}, 0);
    else if (!we) begin
      chk("v_rvalid_last", v_rvalid, 1);
      chk("v_ridx_last", v_ridx, len - 1);
      chk("v_rdata_last", v_rdata, gm[prev]);
    end
    step();
  endtask

  task automatic do_reset;
    rst = 1;
    repeat (2) @(posedge core_clk);
    #1;
    rst = 0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    v_req = 0; v_we = 0; v_base = 0; v_stride = 0; v_len = 0; v_wdata = 0;
    for (int k = 0; k < 1024; k++) gm[k] = 0;
    for (int k = 0; k < 32; k++) vw[k] = 0;
    @(negedge core_clk);
    chk_zero("reset");
    do_reset();

    for (int k = 0; k < 34; k++) vec_burst(1, 10'(k * 31), 10'd1, 5'd31);

    tbl[0] = '{4'hF, 10'd5, 32'h12345678, 32'h0};
    tbl[1] = '{4'h0, 10'd5, 32'h0,        32'h12345678};
    tbl[2] = '{4'h1, 10'd5, 32'h000000AA, 32'h0};
    tbl[3] = '{4'h0, 10'd5, 32'h0,        32'h123456AA};
    tbl[4] = '{4'hC, 10'd7, 32'hBEEF1111, 32'h0};
    tbl[5] = '{4'h0, 10'd7, 32'h0,        32'hBEEF0000};
    tbl[6] = '{4'h0, 10'd6, 32'h0,        32'h0};
    for (int k = 0; k < 7; k++) core_op(tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].exp);

    for (int k = 0; k < 4; k++) vw[k] = 32'hA0 + k;
    vec_burst(1, 10'h010, 10'd2, 5'd4);
    vec_burst(0, 10'h010, 10'd2, 5'd4);
    for (int k = 0; k < 4; k++) vw[k] = 32'hC0DE0000 + k;
    vec_burst(1, 10'h3FE, 10'd1, 5'd4);
    vec_burst(0, 10'h3FE, 10'd1, 5'd4);
    vec_burst(0, 10'h055, 10'd3, 5'd0);

    do_reset();
    c_req = 1; c_we = 0; c_addr = 10'd5;
    v_req = 1; v_we = 0; v_base = 10'h010; v_stride = 10'd2; v_len = 5'd3;
    @(negedge core_clk);
    chk("sim_c_first", {c_gnt, v_gnt}, 2'b10);
    step();
    @(negedge core_clk);
    chk("sim_v_second", {c_gnt, v_gnt}, 2'b01);
    step();
    v_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge core_clk);
      chk("sim_c_stall", c_gnt, 0);
      chk("sim_addr", data_addr, 10'h010 + 10'(2 * k));
      step();
    end
    @(negedge core_clk);
    chk("sim_c_third", {c_gnt, v_done}, 2'b11);
    step();
    c_req = 0;
    step();

    for (int k = 0; k < 8; k++) vw[k] = 32'hDEAD0000 + k;
    vec_burst(1, 10'h100, 10'd1, 5'd8);
    v_req = 1; v_we = 1; v_base = 10'h100; v_stride = 10'd1; v_len = 5'd8;
    begin
      bit ok;
      wait_gnt(1, ok);
    end
    step();
    v_req = 0;
    for (int k = 0; k < 2; k++) begin
      v_wdata = 32'h55000000 + k;
      @(negedge core_clk);
      chk("rb_addr", data_addr, 10'h100 + 10'(k));
      gm[10'h100 + k] = 32'h55000000 + k;
      step();
    end
    v_wdata = 32'h55000002;
    @(negedge core_clk);
    chk("rb_el2_issued", dm_write, 4'hF);
    rst = 1;
    #1;
    chk_zero("rb_async");
    @(posedge core_clk);
    #1;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge core_clk);
      chk("rb_no_done", {v_done, v_rvalid, dm_write}, 0);
      step();
    end
    for (int k = 0; k < 8; k++) core_op(4'h0, 10'h100 + 10'(k), 32'h0, gm[10'h100 + k]);

    for (int n = 0; n < 40; n++) begin
      int r;
      logic [9:0] a;
      r = $urandom_range(0, 3);
      a = 10'($urandom_range(0, 1023));
      if (r == 0) core_op(4'($urandom_range(1, 15)), a, $urandom, 32'h0);
      else if (r == 1) core_op(4'h0, a, 32'h0, gm[a]);
      else begin
        for (int k = 0; k < 32; k++) vw[k] = $urandom;
        vec_burst(1'($urandom_range(0, 1)), a, 10'($urandom_range(0, 1023)),
                  5'($urandom_range(0, 31)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
